fp32_to_int_seq: RTL and testbench
==================================

Name: fp32_to_int_seq

Overview:
- Iterative converter from IEEE-754 single precision to signed 32-bit integer.
- Sits directly downstream of the floating-point divider. It consumes the 32-bit quotient word and hands an integer to fixed-point consumers such as counters and address math.
- Shifts one bit position per cycle. Uses a valid/ready handshake on both sides.

Parameters:
- ROUND_NEAREST, 0: 0 = truncate toward zero, matching the divider's truncating quotient; 1 = round to nearest, ties to even.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a float to convert.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  32  IEEE-754 single operand.
- out_valid  out  1  out_data/flags valid, held until out_ready.
- out_ready  in  1  consumer takes the result.
- out_data  out  32  signed two's-complement result.
- flag_inexact  out  1  discarded nonzero fraction, or nonzero denormal flushed.
- flag_overflow  out  1  magnitude out of int32 range, or infinity; result saturated.
- flag_invalid  out  1  NaN operand.

Behaviour:
- Reset:
  - state=IDLE; out_valid=0, out_data=0, all flags=0; in_ready=1 on the cycle after reset.
  - Reset mid-operation aborts the conversion and discards it.
- Handshakes:
  - Input is accepted on the posedge where in_valid && in_ready.
  - Output transfers on the posedge where out_valid && out_ready.
  - in_ready = (state==IDLE), driven combinationally from state. No overlap: one conversion in flight.
- Classify, on the accepting edge. Let s=in_data[31], x=in_data[30:23], m=in_data[22:0], e=x-127 (signed):
  - x==255, m!=0: result 0x80000000, invalid=1.
  - x==255, m==0: saturate, overflow=1.
  - Saturation value: s=0 gives 0x7FFFFFFF; s=1 gives 0x80000000.
  - x==0: result 0; inexact=(m!=0). Denormals are flushed.
  - e==31, s==1, m==0: result 0x80000000, no flags.
  - e>=31 otherwise: saturate, overflow=1.
  - e<-1, or e==-1 with ROUND_NEAREST=0: result 0, inexact=1.
  - Otherwise: mag={1,m} (24 bits, in a 32-bit register).
    - Left shift count n=e-23 when e>=23 (max 7).
    - Right shift count n=23-e when e<23 (max 24).
  - Specials use n=0.
- States: IDLE -> SHIFT -> DONE.
  - IDLE -> SHIFT on accept.
  - SHIFT does one shift per cycle and decrements cnt (5 bits) while cnt!=0.
  - SHIFT does the finish step on the edge where cnt==0.
- Right shifts:
  - guard receives the bit shifted out.
  - Any previous guard ORs into sticky.
- Finish step:
  - inexact |= guard|sticky.
  - If ROUND_NEAREST and guard && (sticky || mag[0]): mag+=1. This cannot exceed 2^31-1 for e<=30.
  - If s: out_data=-mag, else out_data=mag.
  - out_valid=1; state=DONE.
- Latency: out_valid rises n+1 cycles after the accepting edge. Specials give 1 cycle; worst case is 25 cycles.
- DONE:
  - out_data and flags are held stable while out_ready=0.
  - On transfer: out_valid=0, state=IDLE; the next input is accepted at earliest the following edge.
- Zero of either sign: 0x00000000, no flags.
- Flags are valid only while out_valid=1. They are cleared on each accept.

Decomposition:
- Shared package fp32_pkg:
  - Field widths: EXP_W=8, MAN_W=23.
  - EXP_BIAS=127, INT32_MAX=0x7FFFFFFF, INT32_MIN=0x80000000.
  - State encoding: IDLE/SHIFT/DONE.
- Sub-module fp32_unpack (combinational): splits the word into s/x/m and decodes is_zero/is_denorm/is_inf/is_nan. Reusable by the divider's special-case logic.

Test Plan:
- 0x40F8A3D7 (7.77), ROUND_NEAREST=0 -> out_data=0x00000007, inexact=1, out_valid 22 cycles after accept (n=21).
- 0xC0800000 (-4.0) -> 0xFFFFFFFC, no flags.
- Large magnitudes:
  - 0x4B800001 (16777218.0) -> 0x01000002, exact, left shift n=1.
  - 0x4F000000 -> 0x7FFFFFFF with overflow=1.
  - 0xCF000000 -> 0x80000000 with no flags.
- Specials:
  - 0x7FC00000 (NaN) -> 0x80000000, invalid=1, latency 1 cycle.
  - 0xFF800000 (-inf) -> 0x80000000, overflow=1.
  - 0x00000001 (denormal) -> 0, inexact=1.
- ROUND_NEAREST=1:
  - 0x3FC00000 (1.5) -> 2.
  - 0x40200000 (2.5) -> 2.
  - 0x3F000000 (0.5) -> 0, inexact=1.
  - 0x3F400000 (0.75) -> 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> out_data/flags stable, in_ready=0, no second accept.
  - Then pulse out_ready -> next accept exactly one edge later.
  - Assert rst in SHIFT mid-conversion -> out_valid=0 and in_ready=1 on the following cycle, and no stale result appears.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared definitions for single-precision float helpers: field widths,
// exponent bias, int32 saturation limits and the converter state encoding.
package fp32_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned MAN_W    = 23;
   localparam int unsigned EXP_BIAS = 127;

   localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational IEEE-754 single-precision field splitter and class decoder.
module fp32_unpack
   import fp32_pkg::*;
(
   input  logic [31:0]      word,
   output logic             sign,
   output logic [EXP_W-1:0] exp_field,
   output logic [MAN_W-1:0] man,
   output logic             is_zero,
   output logic             is_denorm,
   output logic             is_inf,
   output logic             is_nan
);

   // Split the word into fields and decode the operand class.
   always_comb begin
      sign      = word[31];
      exp_field = word[30:23];
      man       = word[22:0];
      is_zero   = (exp_field == '0) && (man == '0);
      is_denorm = (exp_field == '0) && (man != '0);
      is_inf    = (exp_field == '1) && (man == '0);
      is_nan    = (exp_field == '1) && (man != '0);
   end

endmodule

// File: rtl/fp32_to_int_seq.sv
// Iterative float32 -> int32 converter. Classifies the operand on accept,
// then shifts the significand one bit per cycle toward the binary point
// and finishes with optional round-to-nearest-even and sign application.
module fp32_to_int_seq
   import fp32_pkg::*;
#(
   parameter int ROUND_NEAREST = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        flag_inexact,
   output logic        flag_overflow,
   output logic        flag_invalid
);

   localparam logic RN = (ROUND_NEAREST != 0);

   state_t state_q, state_d;

   logic [31:0] mag_q;
   logic [4:0]  cnt_q;
   logic        left_q;
   logic        sign_q;
   logic        guard_q;
   logic        sticky_q;

   logic             u_sign;
   logic [EXP_W-1:0] u_exp;
   logic [MAN_W-1:0] u_man;
   logic             u_zero, u_denorm, u_inf, u_nan;

   logic signed [9:0] exp_unb;
   logic [31:0]       c_mag;
   logic [4:0]        c_cnt;
   logic              c_left, c_sign, c_inexact, c_overflow, c_invalid;

   logic        round_up;
   logic [31:0] mag_rnd;
   logic [31:0] result;

   fp32_unpack u_unpack (
      .word      (in_data),
      .sign      (u_sign),
      .exp_field (u_exp),
      .man       (u_man),
      .is_zero   (u_zero),
      .is_denorm (u_denorm),
      .is_inf    (u_inf),
      .is_nan    (u_nan)
   );

   // Classify the incoming operand into a preloaded magnitude, shift plan and flags.
   // Specials load their final value with sign cleared and a zero shift count,
   // so they ride the normal finish step unchanged.
   always_comb begin
      exp_unb    = $signed({2'b00, u_exp}) - $signed(10'(EXP_BIAS));
      c_mag      = '0;
      c_cnt      = '0;
      c_left     = 1'b0;
      c_sign     = 1'b0;
      c_inexact  = 1'b0;
      c_overflow = 1'b0;
      c_invalid  = 1'b0;
      if (u_nan) begin
         c_mag     = INT32_MIN;
         c_invalid = 1'b1;
      end else if (u_inf) begin
         c_mag      = u_sign ? INT32_MIN : INT32_MAX;
         c_overflow = 1'b1;
      end else if (u_zero || u_denorm) begin
         c_inexact = u_denorm;
      end else if (exp_unb >= 10'sd31) begin
         if (u_sign && (u_man == '0) && (exp_unb == 10'sd31)) begin
            c_mag = INT32_MIN;
         end else begin
            c_mag      = u_sign ? INT32_MIN : INT32_MAX;
            c_overflow = 1'b1;
         end
      end else if ((exp_unb < -10'sd1) || ((exp_unb == -10'sd1) && !RN)) begin
         c_inexact = 1'b1;
      end else begin
         c_mag  = {8'h00, 1'b1, u_man};
         c_sign = u_sign;
         // 5-bit modular arithmetic is exact over e in [-1, 30].
         if (exp_unb >= 10'sd23) begin
            c_left = 1'b1;
            c_cnt  = exp_unb[4:0] - 5'd23;
         end else begin
            c_cnt  = 5'd23 - exp_unb[4:0];
         end
      end
   end

   // Finish-step rounding and sign application.
   always_comb begin
      round_up = RN && guard_q && (sticky_q || mag_q[0]);
      mag_rnd  = mag_q + {31'b0, round_up};
      result   = sign_q ? (~mag_rnd + 32'd1) : mag_rnd;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      case (state_q)
         IDLE:    if (in_valid)     state_d = SHIFT;
         SHIFT:   if (cnt_q == '0)  state_d = DONE;
         DONE:    if (out_ready)    state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Datapath: load on accept, shift one bit per cycle, then commit the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         mag_q         <= '0;
         cnt_q         <= '0;
         left_q        <= 1'b0;
         sign_q        <= 1'b0;
         guard_q       <= 1'b0;
         sticky_q      <= 1'b0;
         out_data      <= '0;
         flag_inexact  <= 1'b0;
         flag_overflow <= 1'b0;
         flag_invalid  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mag_q         <= c_mag;
                  cnt_q         <= c_cnt;
                  left_q        <= c_left;
                  sign_q        <= c_sign;
                  guard_q       <= 1'b0;
                  sticky_q      <= 1'b0;
                  flag_inexact  <= c_inexact;
                  flag_overflow <= c_overflow;
                  flag_invalid  <= c_invalid;
               end
            end
            SHIFT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 5'd1;
                  if (left_q) begin
                     mag_q <= {mag_q[30:0], 1'b0};
                  end else begin
                     mag_q    <= {1'b0, mag_q[31:1]};
                     guard_q  <= mag_q[0];
                     sticky_q <= sticky_q | guard_q;
                  end
               end else begin
                  out_data     <= result;
                  flag_inexact <= flag_inexact | guard_q | sticky_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Bench for fp32_to_int_seq: truncating and round-to-nearest instances,
// checked against an arithmetic reference model.
module tb_fp32_to_int_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] in_data;
   logic        tb_valid, tb_ready, sel;

   logic        iv0, iv1, or0, or1;
   logic        ir0, ir1, ov0, ov1;
   logic [31:0] od0, od1;
   logic        ix0, ix1, of0, of1, nv0, nv1;

   logic        cur_ir, cur_ov, cur_ix, cur_of, cur_nv;
   logic [31:0] cur_od;

   assign iv0 = tb_valid & ~sel;
   assign iv1 = tb_valid &  sel;
   assign or0 = tb_ready & ~sel;
   assign or1 = tb_ready &  sel;

   assign cur_ir = sel ? ir1 : ir0;
   assign cur_ov = sel ? ov1 : ov0;
   assign cur_od = sel ? od1 : od0;
   assign cur_ix = sel ? ix1 : ix0;
   assign cur_of = sel ? of1 : of0;
   assign cur_nv = sel ? nv1 : nv0;

   fp32_to_int_seq #(.ROUND_NEAREST(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(or0), .out_data(od0),
      .flag_inexact(ix0), .flag_overflow(of0), .flag_invalid(nv0)
   );

   fp32_to_int_seq #(.ROUND_NEAREST(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(or1), .out_data(od1),
      .flag_inexact(ix1), .flag_overflow(of1), .flag_invalid(nv1)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] e_data;
   logic        e_inx, e_ovf, e_inv;
   bit          armed = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Value-level reference: integer = significand * 2^(e-23), with the
   // discarded fraction compared against one half for rounding.
   function automatic void model(input bit rn, input logic [31:0] f,
                                 output logic [31:0] r, output bit inx,
                                 output bit ovf, output bit inv, output int lat);
      bit s;
      int x, e, sh;
      logic [22:0] m;
      longint unsigned sig, mag, rem, half;
      s = f[31]; x = int'(f[30:23]); m = f[22:0]; e = x - 127;
      r = 32'h0; inx = 0; ovf = 0; inv = 0; lat = 1;
      if (x == 255) begin
         if (m != 0) begin r = 32'h8000_0000; inv = 1; end
         else begin r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ovf = 1; end
      end else if (x == 0) begin
         inx = (m != 0);
      end else if (e >= 31) begin
         if (s && m == 0 && e == 31) r = 32'h8000_0000;
         else begin r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ovf = 1; end
      end else if (e < -1 || (e == -1 && !rn)) begin
         inx = 1;
      end else begin
         sig = 64'h80_0000 | 64'(m);
         if (e >= 23) begin
            mag = sig << (e - 23);
            lat = e - 23 + 1;
         end else begin
            sh   = 23 - e;
            lat  = sh + 1;
            mag  = sig >> sh;
            rem  = sig & ((64'd1 << sh) - 64'd1);
            inx  = (rem != 0);
            half = 64'd1 << (sh - 1);
            if (rn && (rem > half || (rem == half && mag[0]))) mag = mag + 64'd1;
         end
         r = s ? 32'(64'd0 - mag) : 32'(mag);
      end
   endfunction

   // Output checker: whenever the active instance presents a result, it must match the model.
   always @(negedge clk) begin
      if (armed && cur_ov) begin
         chk("out_data", cur_od, e_data);
         chk("flags", {29'b0, cur_ix, cur_of, cur_nv}, {29'b0, e_inx, e_ovf, e_inv});
      end
   end

   task automatic conv(input bit rn, input logic [31:0] d, input int hold, input bit keep);
      int lat, waited, elat;
      logic [31:0] r;
      bit a, b, c;
      sel = rn;
      in_data = d;
      waited = 0;
      while (!cur_ir && waited < 50) begin
         @(posedge clk); #1; waited++;
      end
      chk("in_ready_before_accept", {31'b0, cur_ir}, 32'd1);
      model(rn, d, r, a, b, c, elat);
      e_data = r; e_inx = a; e_ovf = b; e_inv = c;
      tb_valid = 1'b1;
      @(posedge clk); #1;
      armed = 1'b1;
      if (!keep) tb_valid = 1'b0;
      chk("in_ready_after_accept", {31'b0, cur_ir}, 32'd0);
      lat = 0;
      while (!cur_ov && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, elat);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'b0, cur_ov}, 32'd1);
         chk("hold_in_ready", {31'b0, cur_ir}, 32'd0);
      end
      tb_ready = 1'b1;
      @(posedge clk); #1;
      tb_ready = 1'b0;
      armed = 1'b0;
      chk("valid_after_xfer", {31'b0, cur_ov}, 32'd0);
      chk("in_ready_after_xfer", {31'b0, cur_ir}, 32'd1);
   endtask

   typedef struct {
      bit          rn;
      logic [31:0] d;
      logic [31:0] r;
      bit          inx, ovf, inv;
      int          lat;
   } vec_t;

   vec_t tv[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] mr, rw;
      bit ma, mb, mc, seen;
      int ml;

      tv[0]  = '{0, 32'h40F8A3D7, 32'h0000_0007, 1, 0, 0, 22};
      tv[1]  = '{0, 32'hC0800000, 32'hFFFF_FFFC, 0, 0, 0, 22};
      tv[2]  = '{0, 32'h4B800001, 32'h0100_0002, 0, 0, 0, 2};
      tv[3]  = '{0, 32'h4F000000, 32'h7FFF_FFFF, 0, 1, 0, 1};
      tv[4]  = '{0, 32'hCF000000, 32'h8000_0000, 0, 0, 0, 1};
      tv[5]  = '{0, 32'h7FC00000, 32'h8000_0000, 0, 0, 1, 1};
      tv[6]  = '{0, 32'hFF800000, 32'h8000_0000, 0, 1, 0, 1};
      tv[7]  = '{0, 32'h00000001, 32'h0000_0000, 1, 0, 0, 1};
      tv[8]  = '{1, 32'h3FC00000, 32'h0000_0002, 1, 0, 0, 24};
      tv[9]  = '{1, 32'h40200000, 32'h0000_0002, 1, 0, 0, 23};
      tv[10] = '{1, 32'h3F000000, 32'h0000_0000, 1, 0, 0, 25};
      tv[11] = '{1, 32'h3F400000, 32'h0000_0001, 1, 0, 0, 25};
      tv[12] = '{0, 32'h80000000, 32'h0000_0000, 0, 0, 0, 1};
      tv[13] = '{0, 32'h3F800000, 32'h0000_0001, 0, 0, 0, 24};

      rst = 1'b1; tb_valid = 1'b0; tb_ready = 1'b0; sel = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_valid0", {31'b0, ov0}, 32'd0);
      chk("reset_valid1", {31'b0, ov1}, 32'd0);
      chk("reset_ready0", {31'b0, ir0}, 32'd1);
      chk("reset_ready1", {31'b0, ir1}, 32'd1);
      chk("reset_data0", od0, 32'd0);
      chk("reset_flags0", {29'b0, ix0, of0, nv0}, 32'd0);
      chk("reset_flags1", {29'b0, ix1, of1, nv1}, 32'd0);

      foreach (tv[i]) begin
         model(tv[i].rn, tv[i].d, mr, ma, mb, mc, ml);
         chk("model_pin_data", mr, tv[i].r);
         chk("model_pin_flags", {29'b0, ma, mb, mc}, {29'b0, tv[i].inx, tv[i].ovf, tv[i].inv});
         chk("model_pin_latency", ml, tv[i].lat);
         conv(tv[i].rn, tv[i].d, i % 3, 1'b0);
      end

      // Backpressure with input still offered, then back-to-back accept.
      conv(1'b0, 32'h40F8A3D7, 5, 1'b1);
      conv(1'b0, 32'hC0800000, 0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) rw = $urandom;
         else rw = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 162)), 23'($urandom)};
         conv(1'($urandom_range(0, 1)), rw, $urandom_range(0, 2), 1'b0);
      end

      // Reset in the middle of a long right shift.
      sel = 1'b0; in_data = 32'h3F800000; tb_valid = 1'b1;
      @(posedge clk); #1 tb_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("midreset_valid", {31'b0, ov0}, 32'd0);
      chk("midreset_ready", {31'b0, ir0}, 32'd1);
      chk("midreset_data", od0, 32'd0);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (ov0 || ov1) seen = 1'b1;
      end
      chk("no_stale_result", {31'b0, seen}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
